op_lut_arp_table: RTL and testbench

//  ARP lookup table of the CAM router output-port-lookup stage; sits directly downstream of the
//  op-lut register block and consumes its arp_rd_*/arp_wr_* table-access interface. Stores

---
 rtl/op_lut_pkg.sv | 19 +
 rtl/op_lut_arp_cam_match.sv | 32 +++
 rtl/op_lut_arp_table.sv | 175 +++++++++++++++++
 tb/tb_op_lut_arp_table.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/op_lut_pkg.sv
// op_lut_pkg: definitions shared by the output-port-lookup ARP table and its CAM matcher.
//   ARP_IP_WIDTH / ARP_MAC_WIDTH : field widths of one table entry
//   ARP_INVALID_IP               : IP value that marks an entry empty (never matches)
//   arp_acc_state_e              : host access FSM states
package op_lut_pkg;

  localparam int unsigned ARP_IP_WIDTH  = 32;
  localparam int unsigned ARP_MAC_WIDTH = 48;

  localparam logic [ARP_IP_WIDTH-1:0] ARP_INVALID_IP = 32'h0;

  typedef enum logic [1:0] {
    StIdle        = 2'd0,
    StWrAck       = 2'd1,
    StRdAck       = 2'd2,
    StWaitRelease = 2'd3
  } arp_acc_state_e;

endpackage

// File: rtl/op_lut_arp_cam_match.sv
// op_lut_arp_cam_match: combinational compare of a key IP against every table IP, followed by a
// lowest-index priority encoder.
//   key_i  : IP being resolved
//   ips_i  : IP field of every table entry (entry i at ips_i[i])
//   hit_o  : at least one valid entry equals key_i
//   idx_o  : lowest matching entry index (0 when hit_o = 0)
module op_lut_arp_cam_match
  import op_lut_pkg::*;
#(
  parameter int unsigned DepthBits = 4,
  localparam int unsigned Depth    = 2 ** DepthBits
) (
  input  logic [ARP_IP_WIDTH-1:0]             key_i,
  input  logic [Depth-1:0][ARP_IP_WIDTH-1:0]  ips_i,
  output logic                                hit_o,
  output logic [DepthBits-1:0]                idx_o
);

  always_comb begin
    hit_o = 1'b0;
    idx_o = '0;
    // Walk from the top down so the lowest matching index is the last one assigned.
    // A zero key can never hit, which also keeps empty (ip = 0) entries out of the result.
    for (int i = int'(Depth) - 1; i >= 0; i--) begin
      if ((key_i != ARP_INVALID_IP) && (ips_i[i] == key_i)) begin
        hit_o = 1'b1;
        idx_o = DepthBits'(i);
      end
    end
  end

endmodule

// File: rtl/op_lut_arp_table.sv
// op_lut_arp_table: next-hop IP -> MAC table for the output-port-lookup stage.
//   clk, reset                          : single clock, synchronous active-high reset
//   lookup_req, next_hop_ip             : lookup request (one per cycle, no backpressure)
//   lookup_done, arp_lookup_hit, arp_mac: result, exactly two cycles after lookup_req
//   rd_req/rd_addr -> rd_ack/rd_ip/rd_mac: host read, req held until one-cycle ack
//   wr_req/wr_addr/wr_ip/wr_mac -> wr_ack: host write, req held until one-cycle ack
// An entry is valid iff its IP is non-zero; writing ip = 0 invalidates it.
module op_lut_arp_table
  import op_lut_pkg::*;
#(
  parameter int unsigned ARP_LUT_DEPTH_BITS = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  // Lookup port
  input  logic                          lookup_req,
  input  logic [ARP_IP_WIDTH-1:0]       next_hop_ip,
  output logic                          lookup_done,
  output logic [ARP_MAC_WIDTH-1:0]      arp_mac,
  output logic                          arp_lookup_hit,
  // Host read
  input  logic [ARP_LUT_DEPTH_BITS-1:0] rd_addr,
  input  logic                          rd_req,
  output logic [ARP_MAC_WIDTH-1:0]      rd_mac,
  output logic [ARP_IP_WIDTH-1:0]       rd_ip,
  output logic                          rd_ack,
  // Host write
  input  logic [ARP_LUT_DEPTH_BITS-1:0] wr_addr,
  input  logic                          wr_req,
  input  logic [ARP_MAC_WIDTH-1:0]      wr_mac,
  input  logic [ARP_IP_WIDTH-1:0]       wr_ip,
  output logic                          wr_ack
);

  localparam int unsigned ARP_LUT_DEPTH = 2 ** ARP_LUT_DEPTH_BITS;

  // Table storage
  logic [ARP_LUT_DEPTH-1:0][ARP_IP_WIDTH-1:0]  tbl_ip_q, tbl_ip_d;
  logic [ARP_LUT_DEPTH-1:0][ARP_MAC_WIDTH-1:0] tbl_mac_q, tbl_mac_d;

  // Lookup pipeline
  logic                          lk_vld_q, lk_vld_d;
  logic [ARP_IP_WIDTH-1:0]       lk_ip_q, lk_ip_d;
  logic                          done_q, done_d;
  logic                          hit_q, hit_d;
  logic [ARP_MAC_WIDTH-1:0]      mac_q, mac_d;
  logic                          cam_hit;
  logic [ARP_LUT_DEPTH_BITS-1:0] cam_idx;

  // Host access FSM
  arp_acc_state_e                state_q, state_d;
  logic                          served_wr_q, served_wr_d;
  logic                          wr_lock_q, wr_lock_d;
  logic                          rd_lock_q, rd_lock_d;
  logic                          wr_ack_q, wr_ack_d;
  logic                          rd_ack_q, rd_ack_d;
  logic [ARP_IP_WIDTH-1:0]       rd_ip_q, rd_ip_d;
  logic [ARP_MAC_WIDTH-1:0]      rd_mac_q, rd_mac_d;
  logic                          wr_go, rd_go, other_pending;

  op_lut_arp_cam_match #(
    .DepthBits (ARP_LUT_DEPTH_BITS)
  ) u_cam_match (
    .key_i (lk_ip_q),
    .ips_i (tbl_ip_q),
    .hit_o (cam_hit),
    .idx_o (cam_idx)
  );

  // Stage 1 registers the key; stage 2 compares against the table as it stands in that cycle
  // and registers the final hit/MAC, so a later write cannot disturb an in-flight result.
  always_comb begin
    lk_vld_d = lookup_req;
    lk_ip_d  = next_hop_ip;
    done_d   = lk_vld_q;
    hit_d    = lk_vld_q & cam_hit;
    mac_d    = (lk_vld_q && cam_hit) ? tbl_mac_q[cam_idx] : '0;
  end

  // A request type is locked once served and stays locked until its req drops, so a req that is
  // still held high is never acknowledged twice.
  assign wr_go         = wr_req & ~wr_lock_q;
  assign rd_go         = rd_req & ~rd_lock_q;
  assign other_pending = served_wr_q ? rd_go : wr_go;

  always_comb begin
    state_d     = state_q;
    served_wr_d = served_wr_q;
    wr_lock_d   = wr_lock_q & wr_req;
    rd_lock_d   = rd_lock_q & rd_req;
    wr_ack_d    = 1'b0;
    rd_ack_d    = 1'b0;
    rd_ip_d     = rd_ip_q;
    rd_mac_d    = rd_mac_q;
    tbl_ip_d    = tbl_ip_q;
    tbl_mac_d   = tbl_mac_q;

    unique case (state_q)
      StIdle: begin
        // Write has priority when both requests are presented together.
        if (wr_go) begin
          tbl_ip_d[wr_addr]  = wr_ip;
          tbl_mac_d[wr_addr] = wr_mac;
          wr_lock_d          = 1'b1;
          served_wr_d        = 1'b1;
          wr_ack_d           = 1'b1;
          state_d            = StWrAck;
        end else if (rd_go) begin
          rd_ip_d     = tbl_ip_q[rd_addr];
          rd_mac_d    = tbl_mac_q[rd_addr];
          rd_lock_d   = 1'b1;
          served_wr_d = 1'b0;
          rd_ack_d    = 1'b1;
          state_d     = StRdAck;
        end
      end
      StWrAck, StRdAck: begin
        state_d = StWaitRelease;
      end
      StWaitRelease: begin
        if ((!wr_req && !rd_req) || other_pending) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tbl_ip_q    <= '0;
      tbl_mac_q   <= '0;
      lk_vld_q    <= 1'b0;
      lk_ip_q     <= '0;
      done_q      <= 1'b0;
      hit_q       <= 1'b0;
      mac_q       <= '0;
      state_q     <= StIdle;
      served_wr_q <= 1'b0;
      wr_lock_q   <= 1'b0;
      rd_lock_q   <= 1'b0;
      wr_ack_q    <= 1'b0;
      rd_ack_q    <= 1'b0;
      rd_ip_q     <= '0;
      rd_mac_q    <= '0;
    end else begin
      tbl_ip_q    <= tbl_ip_d;
      tbl_mac_q   <= tbl_mac_d;
      lk_vld_q    <= lk_vld_d;
      lk_ip_q     <= lk_ip_d;
      done_q      <= done_d;
      hit_q       <= hit_d;
      mac_q       <= mac_d;
      state_q     <= state_d;
      served_wr_q <= served_wr_d;
      wr_lock_q   <= wr_lock_d;
      rd_lock_q   <= rd_lock_d;
      wr_ack_q    <= wr_ack_d;
      rd_ack_q    <= rd_ack_d;
      rd_ip_q     <= rd_ip_d;
      rd_mac_q    <= rd_mac_d;
    end
  end

  assign lookup_done    = done_q;
  assign arp_lookup_hit = hit_q;
  assign arp_mac        = mac_q;
  assign wr_ack         = wr_ack_q;
  assign rd_ack         = rd_ack_q;
  assign rd_ip          = rd_ip_q;
  assign rd_mac         = rd_mac_q;

endmodule

// File: tb/tb_op_lut_arp_table.sv
// Self-checking bench for op_lut_arp_table against a behavioural table model.
module tb_op_lut_arp_table;

  localparam int DB = 4;
  localparam int N  = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          lookup_req;
  logic [31:0]   next_hop_ip;
  logic          lookup_done;
  logic [47:0]   arp_mac;
  logic          arp_lookup_hit;
  logic [DB-1:0] rd_addr;
  logic          rd_req;
  logic [47:0]   rd_mac;
  logic [31:0]   rd_ip;
  logic          rd_ack;
  logic [DB-1:0] wr_addr;
  logic          wr_req;
  logic [47:0]   wr_mac;
  logic [31:0]   wr_ip;
  logic          wr_ack;

  int errors = 0;
  int checks = 0;

  logic [31:0] m_ip [N];
  logic [47:0] m_mac[N];

  op_lut_arp_table #(.ARP_LUT_DEPTH_BITS(DB)) dut (
    .clk            (clk),
    .reset          (reset),
    .lookup_req     (lookup_req),
    .next_hop_ip    (next_hop_ip),
    .lookup_done    (lookup_done),
    .arp_mac        (arp_mac),
    .arp_lookup_hit (arp_lookup_hit),
    .rd_addr        (rd_addr),
    .rd_req         (rd_req),
    .rd_mac         (rd_mac),
    .rd_ip          (rd_ip),
    .rd_ack         (rd_ack),
    .wr_addr        (wr_addr),
    .wr_req         (wr_req),
    .wr_mac         (wr_mac),
    .wr_ip          (wr_ip),
    .wr_ack         (wr_ack)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: lowest index whose IP equals the key; IP 0 never resolves.
  function automatic logic [48:0] model_lookup(input logic [31:0] ip);
    if (ip == 32'h0) return {1'b0, 48'h0};
    for (int i = 0; i < N; i++) begin
      if (m_ip[i] == ip) return {1'b1, m_mac[i]};
    end
    return {1'b0, 48'h0};
  endfunction

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      m_ip[i]  = '0;
      m_mac[i] = '0;
    end
  endtask

  task automatic host_write(input logic [DB-1:0] idx, input logic [31:0] ip,
                            input logic [47:0] mac, output int acks);
    wr_addr = idx; wr_ip = ip; wr_mac = mac; wr_req = 1'b1;
    acks = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (wr_ack) acks++;
    end
    wr_req = 1'b0;
    tick(); tick();
  endtask

  task automatic host_read(input logic [DB-1:0] idx, output int acks,
                           output logic [31:0] ip, output logic [47:0] mac);
    rd_addr = idx; rd_req = 1'b1;
    acks = 0; ip = 'x; mac = 'x;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (rd_ack) begin
        acks++;
        ip  = rd_ip;
        mac = rd_mac;
      end
    end
    rd_req = 1'b0;
    tick(); tick();
  endtask

  // Single lookup: done must be low one cycle after the request and high the cycle after.
  task automatic do_lookup(input logic [31:0] ip, output logic ok_timing,
                           output logic hit, output logic [47:0] mac);
    logic early;
    lookup_req = 1'b1; next_hop_ip = ip;
    tick();
    early = lookup_done;
    lookup_req = 1'b0; next_hop_ip = '0;
    tick();
    ok_timing = lookup_done && !early;
    hit = arp_lookup_hit;
    mac = arp_mac;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    checks++;
    if ({lookup_done, arp_lookup_hit, arp_mac, rd_ack, wr_ack, rd_ip, rd_mac} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got done=%b hit=%b mac=%h rack=%b wack=%b rip=%h rmac=%h, want all 0",
               lookup_done, arp_lookup_hit, arp_mac, rd_ack, wr_ack, rd_ip, rd_mac);
    end
    reset = 1'b0;
    tick();
    model_clear();
  endtask

  task automatic test_empty_table();
    logic ok; logic hit; logic [47:0] mac; int acks; logic [31:0] rip; logic [47:0] rmac;
    do_lookup(32'h0A000001, ok, hit, mac);
    checks++;
    if (!ok || hit !== 1'b0 || mac !== 48'h0) begin
      errors++;
      $display("FAIL empty_lookup: got timing_ok=%b hit=%b mac=%h, want 1/0/0", ok, hit, mac);
    end
    host_read(4'd3, acks, rip, rmac);
    checks++;
    if (acks != 1 || rip !== 32'h0 || rmac !== 48'h0) begin
      errors++;
      $display("FAIL empty_read: got acks=%0d ip=%h mac=%h, want 1/0/0", acks, rip, rmac);
    end
  endtask

  task automatic test_write_read();
    logic ok; logic hit; logic [47:0] mac; int acks; logic [31:0] rip; logic [47:0] rmac;
    host_write(4'd2, 32'h0A000001, 48'h001122334455, acks);
    m_ip[2] = 32'h0A000001; m_mac[2] = 48'h001122334455;
    checks++;
    if (acks != 1) begin
      errors++;
      $display("FAIL write_ack_count: got %0d, want 1", acks);
    end
    do_lookup(32'h0A000001, ok, hit, mac);
    checks++;
    if (!ok || hit !== 1'b1 || mac !== 48'h001122334455) begin
      errors++;
      $display("FAIL write_lookup: got timing_ok=%b hit=%b mac=%h, want 1/1/001122334455",
               ok, hit, mac);
    end
    host_read(4'd2, acks, rip, rmac);
    checks++;
    if (acks != 1 || rip !== 32'h0A000001 || rmac !== 48'h001122334455) begin
      errors++;
      $display("FAIL write_readback: got acks=%0d ip=%h mac=%h, want 1/0a000001/001122334455",
               acks, rip, rmac);
    end
  endtask

  task automatic test_duplicates();
    logic ok; logic hit; logic [47:0] mac; int acks;
    host_write(4'd5, 32'h0A000007, 48'hAAAAAA000005, acks);
    host_write(4'd1, 32'h0A000007, 48'hBBBBBB000001, acks);
    m_ip[5] = 32'h0A000007; m_mac[5] = 48'hAAAAAA000005;
    m_ip[1] = 32'h0A000007; m_mac[1] = 48'hBBBBBB000001;
    do_lookup(32'h0A000007, ok, hit, mac);
    checks++;
    if (!ok || hit !== 1'b1 || mac !== 48'hBBBBBB000001) begin
      errors++;
      $display("FAIL dup_lowest: got timing_ok=%b hit=%b mac=%h, want 1/1/bbbbbb000001",
               ok, hit, mac);
    end
    host_write(4'd1, 32'h0, 48'hBBBBBB000001, acks);
    m_ip[1] = 32'h0;
    do_lookup(32'h0A000007, ok, hit, mac);
    checks++;
    if (!ok || hit !== 1'b1 || mac !== 48'hAAAAAA000005) begin
      errors++;
      $display("FAIL dup_after_invalidate: got timing_ok=%b hit=%b mac=%h, want 1/1/aaaaaa000005",
               ok, hit, mac);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ips[4];
    logic [48:0] exp;
    ips[0] = 32'h0A000001; ips[1] = 32'hC0A80909; ips[2] = 32'h0A000007; ips[3] = 32'h0;
    for (int k = 0; k < 6; k++) begin
      if (k < 4) begin
        lookup_req = 1'b1; next_hop_ip = ips[k];
      end else begin
        lookup_req = 1'b0; next_hop_ip = '0;
      end
      tick();
      if (k >= 1 && k <= 4) begin
        exp = model_lookup(ips[k-1]);
        checks++;
        if (lookup_done !== 1'b1 || arp_lookup_hit !== exp[48] || arp_mac !== exp[47:0]) begin
          errors++;
          $display("FAIL b2b_%0d: got done=%b hit=%b mac=%h, want 1/%b/%h",
                   k - 1, lookup_done, arp_lookup_hit, arp_mac, exp[48], exp[47:0]);
        end
      end else if (k == 5) begin
        checks++;
        if (lookup_done !== 1'b0) begin
          errors++;
          $display("FAIL b2b_extra_done: got done=%b, want 0", lookup_done);
        end
      end
    end
  endtask

  task automatic test_same_cycle_rw();
    int wcnt = 0, rcnt = 0, wcyc = -1, rcyc = -1;
    logic [31:0] rip = '0;
    logic [47:0] rmac = '0;
    wr_addr = 4'd9; wr_ip = 32'h0A000909; wr_mac = 48'h0000CAFE0909;
    rd_addr = 4'd9;
    wr_req = 1'b1; rd_req = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (wr_ack) begin wcnt++; wcyc = c; end
      if (rd_ack) begin rcnt++; rcyc = c; rip = rd_ip; rmac = rd_mac; end
    end
    wr_req = 1'b0; rd_req = 1'b0;
    repeat (3) tick();
    m_ip[9] = 32'h0A000909; m_mac[9] = 48'h0000CAFE0909;
    checks++;
    if (wcnt != 1 || rcnt != 1) begin
      errors++;
      $display("FAIL rw_ack_counts: got wr=%0d rd=%0d, want 1/1", wcnt, rcnt);
    end
    checks++;
    if (wcyc != 1 || rcyc <= wcyc) begin
      errors++;
      $display("FAIL rw_order: got wr_cycle=%0d rd_cycle=%0d, want wr at 1 then rd later",
               wcyc, rcyc);
    end
    checks++;
    if (rip !== 32'h0A000909 || rmac !== 48'h0000CAFE0909) begin
      errors++;
      $display("FAIL rw_read_data: got ip=%h mac=%h, want 0a000909/0000cafe0909", rip, rmac);
    end
  endtask

  task automatic test_random();
    logic [31:0] pool[5];
    logic ok; logic hit; logic [47:0] mac; int acks;
    logic [48:0] exp;
    logic [DB-1:0] idx;
    logic [31:0] ip;
    pool[0] = 32'h0A000001; pool[1] = 32'h0A000002; pool[2] = 32'h0A000003;
    pool[3] = 32'hAC100001; pool[4] = 32'h0;
    for (int it = 0; it < 12; it++) begin
      idx = DB'($urandom_range(0, N - 1));
      ip  = pool[$urandom_range(0, 4)];
      mac = {16'($urandom()), $urandom()};
      host_write(idx, ip, mac, acks);
      m_ip[idx] = ip; m_mac[idx] = mac;
      checks++;
      if (acks != 1) begin
        errors++;
        $display("FAIL rand_wr_ack_%0d: got %0d acks, want 1", it, acks);
      end
      ip = ($urandom_range(0, 5) == 5) ? 32'hDEAD0001 : pool[$urandom_range(0, 4)];
      exp = model_lookup(ip);
      do_lookup(ip, ok, hit, mac);
      checks++;
      if (!ok || hit !== exp[48] || mac !== exp[47:0]) begin
        errors++;
        $display("FAIL rand_lookup_%0d ip=%h: got timing_ok=%b hit=%b mac=%h, want 1/%b/%h",
                 it, ip, ok, hit, mac, exp[48], exp[47:0]);
      end
    end
  endtask

  task automatic test_reset_midflight();
    int acks; logic [31:0] rip; logic [47:0] rmac;
    logic ok; logic hit; logic [47:0] mac;
    // Make sure at least one entry is valid before the reset.
    host_write(4'd4, 32'h0A000044, 48'h444444444444, acks);
    lookup_req = 1'b1; next_hop_ip = 32'h0A000044;
    tick();
    reset = 1'b1; lookup_req = 1'b0;
    wr_addr = 4'd7; wr_ip = 32'h0A000077; wr_mac = 48'h777777777777; wr_req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (lookup_done !== 1'b0 || wr_ack !== 1'b0) begin
        errors++;
        $display("FAIL reset_flight_%0d: got done=%b wr_ack=%b, want 0/0", k, lookup_done, wr_ack);
      end
      if (k == 1) begin
        reset = 1'b0; wr_req = 1'b0;
      end
    end
    tick();
    model_clear();
    for (int i = 0; i < N; i++) begin
      host_read(DB'(i), acks, rip, rmac);
      checks++;
      if (acks != 1 || rip !== 32'h0 || rmac !== 48'h0) begin
        errors++;
        $display("FAIL reset_table_%0d: got acks=%0d ip=%h mac=%h, want 1/0/0", i, acks, rip, rmac);
      end
    end
    do_lookup(32'h0A000044, ok, hit, mac);
    checks++;
    if (!ok || hit !== 1'b0 || mac !== 48'h0) begin
      errors++;
      $display("FAIL reset_lookup: got timing_ok=%b hit=%b mac=%h, want 1/0/0", ok, hit, mac);
    end
  endtask

  initial begin
    reset = 1'b1; lookup_req = 1'b0; next_hop_ip = '0;
    rd_addr = '0; rd_req = 1'b0; wr_addr = '0; wr_req = 1'b0; wr_mac = '0; wr_ip = '0;
    test_reset();
    test_empty_table();
    test_write_read();
    test_duplicates();
    test_back_to_back();
    test_same_cycle_rw();
    test_random();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
